factor_search_engine: RTL and testbench



---
 rtl/factor_search_engine.sv | 131 +++++++++++++
 tb/tb_factor_search_engine.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/factor_search_engine.sv
// Sequential 8-bit factor search: trial division by d = 2..15 with a bit-serial restoring divider.
// Emits the smallest-divisor witness (f1 = d, f2 = quotient) or found=0 when no 4-bit pair exists.
module factor_search_engine #(
    parameter int W_A = 8,
    parameter int W_F = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [W_A-1:0] in_a,
    output logic           out_valid,
    input  logic           out_ready,
    output logic           out_found,
    output logic [W_F-1:0] out_f1,
    output logic [W_F-1:0] out_f2,
    output logic           busy
);
    localparam int CNT_W = $clog2(W_A);

    typedef enum logic [1:0] {IDLE, DIV, CHECK, DONE} state_t;

    state_t           state;
    logic             ready_r;
    logic [W_A-1:0]   a_r;
    logic [W_A-1:0]   a_sh;
    logic [W_A-1:0]   q;
    logic [W_F:0]     rem;
    logic [W_F-1:0]   d;
    logic [CNT_W-1:0] cnt;
    logic [W_F:0]     rem_nx;
    logic             q_bit;
    logic             found_now;

    // One restoring step: shift the next dividend bit in, subtract when it fits.
    function automatic logic [W_F+1:0] div_step(input logic [W_F:0]   r,
                                                 input logic           a_bit,
                                                 input logic [W_F-1:0] dv);
        logic [W_F:0] sh;
        sh = {r[W_F-1:0], a_bit};
        if (sh >= {1'b0, dv})
            return {sh - {1'b0, dv}, 1'b1};
        return {sh, 1'b0};
    endfunction

    always_comb begin
        {rem_nx, q_bit} = div_step(rem, a_sh[W_A-1], d);
        found_now       = (rem == '0) && (q[W_A-1:W_F] == '0) && (q >= W_A'(2));
    end

    // Gated so the port reads 0 throughout reset yet is 1 on the first cycle after release.
    assign in_ready = ready_r & rst_n;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            ready_r   <= 1'b1;
            out_valid <= 1'b0;
            out_found <= 1'b0;
            out_f1    <= '0;
            out_f2    <= '0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    ready_r <= 1'b1;
                    if (in_valid && in_ready) begin
                        a_r     <= in_a;
                        a_sh    <= in_a;
                        ready_r <= 1'b0;
                        if (in_a < W_A'(4)) begin
                            state     <= DONE;
                            out_valid <= 1'b1;
                            out_found <= 1'b0;
                            out_f1    <= '0;
                            out_f2    <= '0;
                        end else begin
                            state <= DIV;
                            busy  <= 1'b1;
                            d     <= W_F'(2);
                            cnt   <= '0;
                            rem   <= '0;
                            q     <= '0;
                        end
                    end
                end
                DIV: begin
                    rem  <= rem_nx;
                    q    <= {q[W_A-2:0], q_bit};
                    a_sh <= a_sh << 1;
                    cnt  <= cnt + 1'b1;
                    if (cnt == CNT_W'(W_A - 1))
                        state <= CHECK;
                end
                CHECK: begin
                    if (found_now) begin
                        state     <= DONE;
                        busy      <= 1'b0;
                        out_valid <= 1'b1;
                        out_found <= 1'b1;
                        out_f1    <= d;
                        out_f2    <= q[W_F-1:0];
                    end else if (d == '1) begin
                        // Exit at the last 4-bit divisor so d never wraps.
                        state     <= DONE;
                        busy      <= 1'b0;
                        out_valid <= 1'b1;
                        out_found <= 1'b0;
                        out_f1    <= '0;
                        out_f2    <= '0;
                    end else begin
                        state <= DIV;
                        d     <= d + 1'b1;
                        rem   <= '0;
                        q     <= '0;
                        cnt   <= '0;
                        a_sh  <= a_r;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        ready_r   <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_factor_search_engine.sv
// Bench for factor_search_engine: directed table, backpressure/reset sequences, random targets vs. arithmetic model.
module tb_factor_search_engine;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_a = 8'd0;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic       out_found;
    logic [3:0] out_f1;
    logic [3:0] out_f2;
    logic       busy;

    int n_tests = 0;
    int n_fail  = 0;

    factor_search_engine #(.W_A(8), .W_F(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a),
        .out_valid(out_valid), .out_ready(out_ready), .out_found(out_found),
        .out_f1(out_f1), .out_f2(out_f2), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int a;
        int found;
        int f1;
        int f2;
        int lat;
    } vec_t;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference: smallest d in 2..15 that divides a with a 4-bit cofactor >= 2.
    task automatic model(input int a, output int found, output int f1, output int f2, output int lat);
        found = 0; f1 = 0; f2 = 0; lat = 127;
        if (a < 4) begin
            lat = 1;
        end else begin
            for (int dv = 2; dv <= 15; dv++) begin
                if (found == 0 && a % dv == 0 && a / dv >= 2 && a / dv <= 15) begin
                    found = 1; f1 = dv; f2 = a / dv; lat = 10 + 9 * (dv - 2);
                end
            end
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Handshake one target, measure latency from the handshake cycle, check result and hold period.
    task automatic run_target(input string name, input int a, input int hold, input bit poke,
                              input int ef, input int e1, input int e2, input int elat);
        int t;
        int lat;
        t = 0;
        while (!in_ready && t < 10) begin
            step();
            t++;
        end
        check({name, "_in_ready"}, int'(in_ready), 1);
        in_valid  = 1'b1;
        in_a      = 8'(a);
        out_ready = (hold == 0);
        step();
        in_valid = 1'b0;
        in_a     = 8'($urandom_range(0, 255));
        lat = 1;
        check({name, "_busy_c1"}, int'(busy), (elat > 1) ? 1 : 0);
        while (!out_valid && lat < 200) begin
            step();
            lat++;
        end
        check({name, "_lat"}, lat, elat);
        check({name, "_found"}, int'(out_found), ef);
        check({name, "_f1"}, int'(out_f1), e1);
        check({name, "_f2"}, int'(out_f2), e2);
        check({name, "_busy_done"}, int'(busy), 0);
        for (int i = 0; i < hold; i++) begin
            if (poke) begin
                in_valid = 1'b1;
                in_a     = 8'd35;
            end
            step();
            check({name, "_hold"}, int'({out_valid, out_found, out_f1, out_f2}),
                  (1 << 9) | (ef << 8) | (e1 << 4) | e2);
            check({name, "_hold_ready"}, int'(in_ready), 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        check({name, "_release"}, int'(out_valid), 0);
        step();
        check({name, "_ready_after"}, int'(in_ready), 1);
        check({name, "_idle_busy"}, int'(busy | out_valid), 0);
    endtask

    initial begin
        vec_t vt[9];
        int   mf, m1, m2, ml, ra, t;

        vt[0] = '{6,   1, 2,  3,  10};
        vt[1] = '{143, 1, 11, 13, 91};
        vt[2] = '{225, 1, 15, 15, 127};
        vt[3] = '{13,  0, 0,  0,  127};
        vt[4] = '{34,  0, 0,  0,  127};
        vt[5] = '{0,   0, 0,  0,  1};
        vt[6] = '{1,   0, 0,  0,  1};
        vt[7] = '{3,   0, 0,  0,  1};
        vt[8] = '{4,   1, 2,  2,  10};

        rst_n = 1'b0;
        step();
        step();
        check("rst_in_ready", int'(in_ready), 0);
        check("rst_outputs", int'({out_valid, out_found, out_f1, out_f2, busy}), 0);
        rst_n = 1'b1;
        step();
        check("post_rst_in_ready", int'(in_ready), 1);

        for (int i = 0; i < 9; i++)
            run_target($sformatf("vec%0d_a%0d", i, vt[i].a), vt[i].a, 0, 1'b0,
                       vt[i].found, vt[i].f1, vt[i].f2, vt[i].lat);

        // Backpressure: result held 20 cycles while a second target is offered and refused.
        run_target("bp_a12", 12, 20, 1'b1, 1, 2, 6, 10);
        step();
        check("bp_no_accept", int'({busy, out_valid}), 0);

        // Reset in the middle of a search, then the same target again from scratch.
        t = 0;
        while (!in_ready && t < 10) begin
            step();
            t++;
        end
        in_valid = 1'b1;
        in_a     = 8'd221;
        step();
        in_valid = 1'b0;
        for (int c = 1; c < 40; c++) step();
        check("mid_busy_c40", int'(busy), 1);
        rst_n = 1'b0;
        step();
        check("mid_rst_outputs", int'({out_valid, out_found, out_f1, out_f2, busy}), 0);
        check("mid_rst_in_ready", int'(in_ready), 0);
        rst_n = 1'b1;
        step();
        run_target("after_rst_a221", 221, 0, 1'b0, 0, 0, 0, 127);

        for (int i = 0; i < 30; i++) begin
            ra = (i < 3) ? i + 1 : $urandom_range(0, 255);
            model(ra, mf, m1, m2, ml);
            run_target($sformatf("rnd%0d_a%0d", i, ra), ra, $urandom_range(0, 3), 1'b0, mf, m1, m2, ml);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end
endmodule
